hsl_color_tracker: RTL and testbench
====================================

// Module: hsl_color_tracker
// PURPOSE
//  Downstream of the RGB->HSL converter: classifies each HSL[10,10,10] pixel
//  against a hue/saturation/lightness window, accumulates count, sum-X and sum-Y
//  of matching pixels over a frame, then computes the centroid with a shared
//  sequential restoring divider. Feeds the object-tracking/servo logic once per frame.
// PARAMETERS
//  COORD_W    10   width of iX/iY and oX/oY
//  CNT_W      19   width of match-pixel counter (640x480 = 307200 fits)
//  SUM_W      29   accumulator and divider width; must be >= COORD_W+CNT_W
//  MIN_PIX    64   minimum match count for oFound=1
// PORTS
//  clk          in   1        single clock; every register is on its posedge
//  reset        in   1        synchronous, active-high
//  iHue         in   10       hue from converter, 0..768 (768 == 0, red)
//  iSaturation  in   10       saturation, 0..1023
//  iLightness   in   10       lightness, 0..1023
//  iValid       in   1        HSL pixel and iX/iY valid this cycle
//  iX, iY       in   COORD_W  pixel coordinates, aligned with HSL data
//  iSof, iEof   in   1        start/end-of-frame strobes, one cycle each
//  iHueLo/Hi    in   10       hue window bounds, 0..767
//  iSatMin      in   10       minimum saturation (inclusive)
//  iLightMin/Max in  10       lightness window (inclusive)
//  oX, oY       out  COORD_W  centroid of matching pixels
//  oCount       out  CNT_W    matching-pixel count of last processed frame
//  oFound       out  1        oCount >= MIN_PIX
//  oValid       out  1        one-cycle pulse: oX/oY/oCount/oFound updated
//  oBusy        out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all accumulators, oX, oY, oCount, oFound, oValid = 0.
//  FSM: IDLE -> ACCUM on iSof; ACCUM -> LATCH on iEof; LATCH -> DIV_X (1 cycle);
//   DIV_X (SUM_W cycles) -> DIV_Y (SUM_W cycles) -> DONE (1 cycle) -> IDLE.
//  iSof in IDLE/ACCUM: clear count/sums, latch all threshold inputs (held
//   constant for the frame); a pixel with iValid in the same cycle IS counted.
//  iSof in ACCUM restarts the frame; nothing is output for the aborted frame.
//  iSof/iEof in LATCH, DIV_X, DIV_Y, DONE: ignored; that frame is not tracked.
//  iEof in IDLE: ignored. iEof with iValid same cycle: pixel counted as last.
//  iValid ignored outside ACCUM.
//  Match (combinational on inputs, accumulated same edge):
//   h = (iHue >= 768) ? iHue-768 : iHue;
//   hue_ok = (Lo<=Hi) ? (Lo<=h && h<=Hi) : (h>=Lo || h<=Hi)  (wrap through 0);
//   match = hue_ok && iSaturation>=SatMin && LightMin<=iLightness<=LightMax.
//  On match: count+=1, sumX+=iX, sumY+=iY (zero-extended). count saturates at
//   2^CNT_W-1; sums saturate at 2^SUM_W-1 (no wrap).
//  LATCH: copy count/sums into divider registers.
//  Divider: restoring, 1 quotient bit/cycle, SUM_W bits, dividend=sum,
//   divisor=count; quotient truncated to low COORD_W bits.
//   count==0: divider skipped result forced oX=oY=0, timing unchanged.
//  DONE: register oX, oY, oCount, oFound; oValid=1 this cycle only.
//  Latency: oValid high in the cycle starting 2*SUM_W+2 edges after the edge
//   that sampled iEof (60 cycles at defaults). Outputs hold until next DONE.
//  reset mid-frame or mid-divide: immediate return to reset state; no oValid.
// TESTING
//  1) All-match 4x4 block at X=100..103, Y=200..203, window covers pixels ->
//     oCount=16, oX=101, oY=201, oFound=0 (16<64), oValid exactly 60 cycles after iEof.
//  2) 16x16 block at X=320..335, Y=240..255 -> oCount=256, oX=327, oY=247, oFound=1.
//  3) Hue wrap: Lo=700, Hi=50; pixels hue 720, 10, 768 match, hue 400 does not ->
//     oCount equals number of 720/10/768 pixels only.
//  4) Frame with zero matches -> oCount=0, oX=oY=0, oFound=0, oValid still pulses.
//  5) iSof during DIV_X ignored: result of prior frame still emitted; next frame
//     not accumulated until a later iSof in IDLE; iSof+iValid same cycle counted.
//  6) reset asserted in DIV_Y -> no oValid, all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/hsl_color_tracker_if.sv
// Pixel stream, colour window and centroid result bundle for hsl_color_tracker.
// The master side drives HSL pixels and thresholds; the slave side returns per-frame results.
interface hsl_color_tracker_if #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 19
);
  logic [9:0]         iHue;
  logic [9:0]         iSaturation;
  logic [9:0]         iLightness;
  logic               iValid;
  logic [COORD_W-1:0] iX;
  logic [COORD_W-1:0] iY;
  logic               iSof;
  logic               iEof;
  logic [9:0]         iHueLo;
  logic [9:0]         iHueHi;
  logic [9:0]         iSatMin;
  logic [9:0]         iLightMin;
  logic [9:0]         iLightMax;
  logic [COORD_W-1:0] oX;
  logic [COORD_W-1:0] oY;
  logic [CNT_W-1:0]   oCount;
  logic               oFound;
  logic               oValid;
  logic               oBusy;

  modport master (
    output iHue, iSaturation, iLightness, iValid, iX, iY, iSof, iEof,
           iHueLo, iHueHi, iSatMin, iLightMin, iLightMax,
    input  oX, oY, oCount, oFound, oValid, oBusy
  );

  modport slave (
    input  iHue, iSaturation, iLightness, iValid, iX, iY, iSof, iEof,
           iHueLo, iHueHi, iSatMin, iLightMin, iLightMax,
    output oX, oY, oCount, oFound, oValid, oBusy
  );
endinterface

// File: rtl/hsl_color_tracker.sv
// Classifies HSL pixels against a colour window, accumulates matches per frame and
// computes the centroid with one restoring divider shared between the X and Y sums.
module hsl_color_tracker #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 19,
  parameter int SUM_W   = 29,
  parameter int MIN_PIX = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  hsl_color_tracker_if.slave   bus
);

  localparam int BIT_W = $clog2(SUM_W);

  typedef enum logic [2:0] {IDLE, ACCUM, LATCH, DIV_X, DIV_Y, DONE} state_t;

  state_t             stateQ, stateD;
  logic [BIT_W-1:0]   bitCntQ, bitCntD;
  logic [CNT_W-1:0]   countQ, countD;
  logic [SUM_W-1:0]   sumXQ, sumXD, sumYQ, sumYD;
  logic [9:0]         hueLoQ, hueLoD, hueHiQ, hueHiD, satMinQ, satMinD;
  logic [9:0]         lightMinQ, lightMinD, lightMaxQ, lightMaxD;
  logic [SUM_W-1:0]   remQ, remD, quotQ, quotD;
  logic [CNT_W-1:0]   divisorQ, divisorD;
  logic [COORD_W-1:0] quotXQ, quotXD;
  logic [COORD_W-1:0] oXQ, oXD, oYQ, oYD;
  logic [CNT_W-1:0]   oCountQ, oCountD;
  logic               oFoundQ, oFoundD, oValidQ, oValidD;

  logic               sofAccept, hueOk, pixMatch, accumEn, trialOk, lastBit;
  logic [9:0]         hueLo, hueHi, satMin, lightMin, lightMax, hueNorm;
  logic [CNT_W-1:0]   countBase, countInc;
  logic [SUM_W-1:0]   sumXBase, sumYBase, sumXInc, sumYInc, remStep, quotStep;
  logic [SUM_W:0]     sumXWide, sumYWide, trial, trialDiff, divisorExt;

  // A frame start bypasses the threshold registers so its own pixel is judged by the new window.
  always_comb begin
    sofAccept = bus.iSof && (stateQ == IDLE || stateQ == ACCUM);
    hueLo     = sofAccept ? bus.iHueLo    : hueLoQ;
    hueHi     = sofAccept ? bus.iHueHi    : hueHiQ;
    satMin    = sofAccept ? bus.iSatMin   : satMinQ;
    lightMin  = sofAccept ? bus.iLightMin : lightMinQ;
    lightMax  = sofAccept ? bus.iLightMax : lightMaxQ;
    hueNorm   = (bus.iHue >= 10'd768) ? bus.iHue - 10'd768 : bus.iHue;
    hueOk     = (hueLo <= hueHi) ? (hueNorm >= hueLo && hueNorm <= hueHi)
                                 : (hueNorm >= hueLo || hueNorm <= hueHi);
    pixMatch  = hueOk && (bus.iSaturation >= satMin) &&
                (bus.iLightness >= lightMin) && (bus.iLightness <= lightMax);
    accumEn   = bus.iValid && pixMatch && (stateQ == ACCUM || sofAccept);

    countBase = sofAccept ? '0 : countQ;
    sumXBase  = sofAccept ? '0 : sumXQ;
    sumYBase  = sofAccept ? '0 : sumYQ;
    countInc  = (countBase == '1) ? countBase : countBase + CNT_W'(1);
    sumXWide  = {1'b0, sumXBase} + (SUM_W+1)'(bus.iX);
    sumYWide  = {1'b0, sumYBase} + (SUM_W+1)'(bus.iY);
    sumXInc   = sumXWide[SUM_W] ? '1 : sumXWide[SUM_W-1:0];
    sumYInc   = sumYWide[SUM_W] ? '1 : sumYWide[SUM_W-1:0];

    divisorExt = (SUM_W+1)'(divisorQ);
    trial      = {remQ, quotQ[SUM_W-1]};
    trialDiff  = trial - divisorExt;
    trialOk    = trial >= divisorExt;
    remStep    = trialOk ? trialDiff[SUM_W-1:0] : trial[SUM_W-1:0];
    quotStep   = {quotQ[SUM_W-2:0], trialOk};
    lastBit    = (bitCntQ == BIT_W'(SUM_W-1));
  end

  // Next-state and datapath updates; the divider runs X then Y with the same registers.
  always_comb begin
    stateD    = stateQ;
    bitCntD   = bitCntQ;
    countD    = countQ;
    sumXD     = sumXQ;
    sumYD     = sumYQ;
    hueLoD    = hueLoQ;
    hueHiD    = hueHiQ;
    satMinD   = satMinQ;
    lightMinD = lightMinQ;
    lightMaxD = lightMaxQ;
    remD      = remQ;
    quotD     = quotQ;
    divisorD  = divisorQ;
    quotXD    = quotXQ;
    oXD       = oXQ;
    oYD       = oYQ;
    oCountD   = oCountQ;
    oFoundD   = oFoundQ;
    oValidD   = 1'b0;

    if (sofAccept) begin
      hueLoD    = bus.iHueLo;
      hueHiD    = bus.iHueHi;
      satMinD   = bus.iSatMin;
      lightMinD = bus.iLightMin;
      lightMaxD = bus.iLightMax;
    end
    if (sofAccept || stateQ == ACCUM) begin
      countD = accumEn ? countInc : countBase;
      sumXD  = accumEn ? sumXInc  : sumXBase;
      sumYD  = accumEn ? sumYInc  : sumYBase;
    end

    case (stateQ)
      IDLE: begin
        if (sofAccept) stateD = ACCUM;
      end
      ACCUM: begin
        if (!bus.iSof && bus.iEof) stateD = LATCH;
      end
      LATCH: begin
        stateD   = DIV_X;
        remD     = '0;
        quotD    = sumXQ;
        divisorD = countQ;
        bitCntD  = '0;
      end
      DIV_X, DIV_Y: begin
        remD    = remStep;
        quotD   = quotStep;
        bitCntD = bitCntQ + BIT_W'(1);
        if (lastBit) begin
          bitCntD = '0;
          if (stateQ == DIV_X) begin
            stateD = DIV_Y;
            quotXD = quotStep[COORD_W-1:0];
            remD   = '0;
            quotD  = sumYQ;
          end else begin
            stateD = DONE;
          end
        end
      end
      DONE: begin
        stateD  = IDLE;
        oValidD = 1'b1;
        oCountD = divisorQ;
        oFoundD = (divisorQ >= CNT_W'(MIN_PIX));
        oXD     = (divisorQ == '0) ? '0 : quotXQ;
        oYD     = (divisorQ == '0) ? '0 : quotQ[COORD_W-1:0];
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= IDLE;
      bitCntQ   <= '0;
      countQ    <= '0;
      sumXQ     <= '0;
      sumYQ     <= '0;
      hueLoQ    <= '0;
      hueHiQ    <= '0;
      satMinQ   <= '0;
      lightMinQ <= '0;
      lightMaxQ <= '0;
      remQ      <= '0;
      quotQ     <= '0;
      divisorQ  <= '0;
      quotXQ    <= '0;
      oXQ       <= '0;
      oYQ       <= '0;
      oCountQ   <= '0;
      oFoundQ   <= 1'b0;
      oValidQ   <= 1'b0;
    end else begin
      stateQ    <= stateD;
      bitCntQ   <= bitCntD;
      countQ    <= countD;
      sumXQ     <= sumXD;
      sumYQ     <= sumYD;
      hueLoQ    <= hueLoD;
      hueHiQ    <= hueHiD;
      satMinQ   <= satMinD;
      lightMinQ <= lightMinD;
      lightMaxQ <= lightMaxD;
      remQ      <= remD;
      quotQ     <= quotD;
      divisorQ  <= divisorD;
      quotXQ    <= quotXD;
      oXQ       <= oXD;
      oYQ       <= oYD;
      oCountQ   <= oCountD;
      oFoundQ   <= oFoundD;
      oValidQ   <= oValidD;
    end
  end

  assign bus.oX     = oXQ;
  assign bus.oY     = oYQ;
  assign bus.oCount = oCountQ;
  assign bus.oFound = oFoundQ;
  assign bus.oValid = oValidQ;
  assign bus.oBusy  = (stateQ != IDLE);

endmodule

// File: tb/tb_hsl_color_tracker.sv
// Self-checking bench for hsl_color_tracker: directed frames plus randomized frames
// compared against a per-frame arithmetic reference of the colour window and centroid.
module tb_hsl_color_tracker;

  localparam int LATENCY = 60;
  localparam int LIMIT   = 200;

  typedef struct {
    int hue, sat, light, x, y;
    bit valid;
  } pix_t;

  typedef struct {
    int hueLo, hueHi, satMin, lightMin, lightMax;
  } thr_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  pix_t frameQ[$];
  longint expCount, expSumX, expSumY;

  always #5 clk = ~clk;

  hsl_color_tracker_if #(.COORD_W(10), .CNT_W(19)) bus ();

  hsl_color_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic bit refMatch(input pix_t p, input thr_t t);
    int h;
    bit hueOk;
    h = (p.hue >= 768) ? p.hue - 768 : p.hue;
    if (t.hueLo <= t.hueHi) hueOk = (h >= t.hueLo) && (h <= t.hueHi);
    else                    hueOk = (h >= t.hueLo) || (h <= t.hueHi);
    return hueOk && (p.sat >= t.satMin) && (p.light >= t.lightMin) && (p.light <= t.lightMax);
  endfunction

  function automatic pix_t mkPix(input int hue, input int x, input int y);
    pix_t p;
    p.hue = hue; p.sat = 600; p.light = 500; p.x = x; p.y = y; p.valid = 1'b1;
    return p;
  endfunction

  function automatic pix_t randPix();
    pix_t p;
    p.hue   = int'($urandom_range(0, 768));
    p.sat   = int'($urandom_range(0, 1023));
    p.light = int'($urandom_range(0, 1023));
    p.x     = int'($urandom_range(0, 1023));
    p.y     = int'($urandom_range(0, 1023));
    p.valid = ($urandom_range(0, 4) != 0);
    return p;
  endfunction

  function automatic thr_t randThr();
    thr_t t;
    t.hueLo    = int'($urandom_range(0, 767));
    t.hueHi    = int'($urandom_range(0, 767));
    t.satMin   = int'($urandom_range(0, 400));
    t.lightMin = int'($urandom_range(0, 400));
    t.lightMax = int'($urandom_range(500, 1023));
    return t;
  endfunction

  function automatic thr_t mkThr(input int lo, input int hi);
    thr_t t;
    t.hueLo = lo; t.hueHi = hi; t.satMin = 100; t.lightMin = 100; t.lightMax = 900;
    return t;
  endfunction

  task automatic drivePix(input pix_t p, input bit sof, input bit eof, input thr_t t);
    bus.iHue        = 10'(p.hue);
    bus.iSaturation = 10'(p.sat);
    bus.iLightness  = 10'(p.light);
    bus.iX          = 10'(p.x);
    bus.iY          = 10'(p.y);
    bus.iValid      = p.valid;
    bus.iSof        = sof;
    bus.iEof        = eof;
    bus.iHueLo      = 10'(t.hueLo);
    bus.iHueHi      = 10'(t.hueHi);
    bus.iSatMin     = 10'(t.satMin);
    bus.iLightMin   = 10'(t.lightMin);
    bus.iLightMax   = 10'(t.lightMax);
  endtask

  task automatic idleInputs();
    bus.iValid = 1'b0;
    bus.iSof   = 1'b0;
    bus.iEof   = 1'b0;
  endtask

  // Drives an optional aborted prefix then frameQ; thresholds are scrambled after the frame start.
  task automatic applyStimulus(input thr_t t, input int abortLen);
    expCount = 0; expSumX = 0; expSumY = 0;
    foreach (frameQ[i]) begin
      if (frameQ[i].valid && refMatch(frameQ[i], t)) begin
        expCount = (expCount < 524287) ? expCount + 1 : expCount;
        expSumX  = (expSumX + frameQ[i].x > 536870911) ? 536870911 : expSumX + frameQ[i].x;
        expSumY  = (expSumY + frameQ[i].y > 536870911) ? 536870911 : expSumY + frameQ[i].y;
      end
    end
    for (int i = 0; i < abortLen; i++) begin
      @(negedge clk);
      drivePix(randPix(), i == 0, 1'b0, randThr());
    end
    for (int i = 0; i < frameQ.size(); i++) begin
      @(negedge clk);
      drivePix(frameQ[i], i == 0, i == frameQ.size() - 1, (i == 0) ? t : randThr());
    end
    @(negedge clk);
    idleInputs();
  endtask

  task automatic awaitResult(input string tag, input int startCycles);
    int cycles;
    longint expX, expY;
    cycles = startCycles;
    while (!bus.oValid && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
    end
    expX = (expCount == 0) ? 0 : (expSumX / expCount) % 1024;
    expY = (expCount == 0) ? 0 : (expSumY / expCount) % 1024;
    checkOutput({tag, "_latency"}, cycles, LATENCY);
    checkOutput({tag, "_count"}, bus.oCount, expCount);
    checkOutput({tag, "_x"}, bus.oX, expX);
    checkOutput({tag, "_y"}, bus.oY, expY);
    checkOutput({tag, "_found"}, bus.oFound, expCount >= 64);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, bus.oValid, 0);
  endtask

  task automatic expectQuiet(input string tag, input int nCycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < nCycles; i++) begin
      @(negedge clk);
      if (bus.oValid) pulses++;
    end
    checkOutput({tag, "_novalid"}, pulses, 0);
    checkOutput({tag, "_idle"}, bus.oBusy, 0);
  endtask

  task automatic buildBlock(input int x0, input int y0, input int side, input int hue);
    frameQ.delete();
    for (int y = 0; y < side; y++)
      for (int x = 0; x < side; x++)
        frameQ.push_back(mkPix(hue, x0 + x, y0 + y));
  endtask

  initial begin
    pix_t p;
    thr_t t;
    int hues[4];
    reset = 1'b1;
    idleInputs();
    drivePix(mkPix(0, 0, 0), 1'b0, 1'b0, mkThr(0, 0));
    idleInputs();
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", bus.oValid, 0);
    checkOutput("rst_busy", bus.oBusy, 0);
    checkOutput("rst_count", bus.oCount, 0);
    checkOutput("rst_x", bus.oX, 0);
    reset = 1'b0;

    // Small and large all-matching blocks with hand-derived centroids.
    buildBlock(100, 200, 4, 100);
    applyStimulus(mkThr(50, 150), 0);
    awaitResult("blk4", 0);
    checkOutput("blk4_const_x", bus.oX, 101);
    checkOutput("blk4_const_y", bus.oY, 201);
    buildBlock(320, 240, 16, 100);
    applyStimulus(mkThr(50, 150), 0);
    awaitResult("blk16", 0);
    checkOutput("blk16_const_x", bus.oX, 327);
    checkOutput("blk16_const_count", bus.oCount, 256);

    // Hue window wrapping through zero, including the 768 alias of red.
    hues[0] = 720; hues[1] = 10; hues[2] = 768; hues[3] = 400;
    frameQ.delete();
    for (int i = 0; i < 40; i++) frameQ.push_back(mkPix(hues[i % 4], 10 + i, 500 - i));
    applyStimulus(mkThr(700, 50), 0);
    awaitResult("wrap", 0);
    checkOutput("wrap_const_count", bus.oCount, 30);

    // No pixel in the window still produces a zeroed result pulse.
    buildBlock(50, 60, 5, 300);
    applyStimulus(mkThr(500, 600), 0);
    awaitResult("empty", 0);

    // Frame start during the divide is ignored, as are pixels and end-of-frame while idle.
    buildBlock(10, 20, 3, 100);
    applyStimulus(mkThr(50, 150), 0);
    repeat (5) @(negedge clk);
    drivePix(mkPix(100, 900, 900), 1'b1, 1'b0, mkThr(50, 150));
    @(negedge clk);
    idleInputs();
    awaitResult("sofdiv", 6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drivePix(mkPix(100, 700, 700), 1'b0, i == 2, mkThr(50, 150));
    end
    @(negedge clk);
    idleInputs();
    expectQuiet("stray", 80);
    frameQ.delete();
    for (int i = 0; i < 3; i++) frameQ.push_back(mkPix(100, 30 * i, 40 * i));
    applyStimulus(mkThr(50, 150), 0);
    awaitResult("sofpix", 0);
    checkOutput("sofpix_const_count", bus.oCount, 3);

    // Reset landing in the Y divide cancels the result and clears the outputs.
    buildBlock(200, 300, 4, 100);
    applyStimulus(mkThr(50, 150), 0);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rstdiv_valid", bus.oValid, 0);
    checkOutput("rstdiv_busy", bus.oBusy, 0);
    checkOutput("rstdiv_count", bus.oCount, 0);
    checkOutput("rstdiv_x", bus.oX, 0);
    checkOutput("rstdiv_y", bus.oY, 0);
    checkOutput("rstdiv_found", bus.oFound, 0);
    expectQuiet("rstdiv", 80);

    // Randomized frames, some with a restarted prefix that must be discarded.
    for (int f = 0; f < 12; f++) begin
      t = randThr();
      if (f % 3 == 0) begin
        t.satMin = 0; t.lightMin = 0; t.lightMax = 1023;
      end
      frameQ.delete();
      for (int i = 0; i < int'($urandom_range(1, 220)); i++) begin
        p = randPix();
        frameQ.push_back(p);
      end
      applyStimulus(t, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0);
      awaitResult($sformatf("rand%0d", f), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
